fcs_check_parallel: RTL and testbench
=====================================

# fcs_check_parallel

Parametrised, multi-byte-per-cycle Ethernet FCS (CRC-32) checker. It is the wide-datapath successor to the bit-serial checker and accepts `BYTES` bytes per beat with a partial final beat. Per frame it issues one registered verdict: FCS error plus a runt flag. It sits on the receive path between the MAC byte aligner and the switch ingress buffer. Per-frame statistics counters are an optional build feature.

## Interface
- `BYTES`, default 4: bytes per beat, legal values 1, 2, 4, 8; `DATA_W = 8*BYTES`.
- `MIN_LEN`, default 64: minimum legal frame length in bytes, FCS included.
- `CNT_W`, default 32: width of statistics counters.
- `clk  in  1`: single clock, all logic on rising edge.
- `reset  in  1`: synchronous, active-high reset.
- `in_valid  in  1`: beat qualifier. There is no ready; the block always accepts.
- `in_sof  in  1`: first beat of frame, sampled only with `in_valid`.
- `in_eof  in  1`: last beat of frame, which carries the final FCS byte; sampled only with `in_valid`.
- `in_data  in  DATA_W`: frame bytes; byte 0 (first on wire) is `in_data[7:0]`.
- `in_last_bytes  in  $clog2(BYTES)+1`: valid byte count on the EOF beat, 1..BYTES. Ignored on other beats.
- `out_valid  out  1`: one-cycle verdict strobe.
- `out_error  out  1`: FCS mismatch, qualified by `out_valid`.
- `out_runt  out  1`: frame length < `MIN_LEN`, qualified by `out_valid`.
- `out_len  out  16`: frame length in bytes including FCS, saturating at 0xFFFF.
- `stat_ok`, `stat_bad`, `stat_abort  out  CNT_W`: present only with `FCS_CHECK_STATS_EN`.

## Operation
- **CRC algorithm:** reflected CRC-32, polynomial 0xEDB88320. Each byte is processed LSB first.
  - The register loads 0xFFFF_FFFF at SOF, before the first byte is processed.
  - The register processes every frame byte, including the 4 FCS bytes.
  - The frame is good iff the final register equals the residue 0xDEBB20E3.
- **Bytes processed on a beat:** all `BYTES` lanes on a non-EOF beat. On the EOF beat, lanes 0..`in_last_bytes`-1 only. An `in_last_bytes` value of 0 or greater than `BYTES` is treated as `BYTES`.
- **FSM, two states: IDLE and FRAME.**
  - IDLE, valid&sof&!eof -> FRAME.
  - IDLE, valid&sof&eof -> single-beat frame; verdict issued; stay in IDLE.
  - IDLE, valid&!sof -> beat dropped, no effect.
  - FRAME, valid&!sof&!eof -> accumulate.
  - FRAME, valid&!sof&eof -> verdict issued -> IDLE.
  - FRAME, valid&sof -> current frame is abandoned without a verdict and `stat_abort` increments. The beat starts a new frame, with the same sof/eof handling as in IDLE.
  - FRAME, !valid -> hold all state; gaps of any length are allowed.
- **Length:** a 16-bit saturating byte counter is cleared at SOF and adds the bytes processed on each accepted beat. `out_runt = (len < MIN_LEN)`.
- **Counters** (with the macro only):
  - `stat_ok` increments on each verdict with error=0 and runt=0.
  - `stat_bad` increments on each verdict with error=1 or runt=1.
  - All counters saturate at all-ones.

## Timing
- Verdict latency: `out_valid` rises exactly 1 cycle after the EOF beat is accepted. `out_error`, `out_runt` and `out_len` are registered and are valid in the same cycle.
- Throughput: one beat per cycle sustained. Back-to-back frames are allowed: SOF may arrive in the cycle directly after EOF, or in the same beat as EOF (single-beat frame).
- `out_valid` is high for exactly one cycle per verdict. `out_error`, `out_runt` and `out_len` hold their values until the next verdict.
- Reset values:
  - state = IDLE;
  - `out_valid`, `out_error`, `out_runt` = 0;
  - `out_len` = 0;
  - all stat counters = 0.
- Reset during a frame discards the frame: no verdict, no counter update.
- Reset takes priority over any input in the same cycle.
- Combinational path per beat: `BYTES` chained byte updates. `BYTES=8` must meet the 125 MHz target; the datapath is not pipelined.

## Configuration
- `FCS_CHECK_STATS_EN` defined: the `stat_ok`, `stat_bad` and `stat_abort` ports and their counters exist, with the behaviour in Operation.
- `FCS_CHECK_STATS_EN` undefined: the ports and counters are absent. Verdict behaviour is identical, and an abandoned frame leaves no trace.

## Structure
- **Package `fcs_pkg`:**
  - `CRC32_POLY_REFL` = 32'hEDB88320;
  - `CRC32_INIT` = 32'hFFFF_FFFF;
  - `CRC32_RESIDUE` = 32'hDEBB20E3;
  - function `crc32_byte(crc, byte)`, the 8-step reflected update;
  - FSM state enum typedef.
- **Sub-module `crc32_parallel_update`:**
  - purely combinational, parameter `BYTES`;
  - inputs: current CRC and one beat;
  - outputs: an array of `BYTES` intermediate CRCs, one after each byte count 1..BYTES;
  - the top level selects the intermediate CRC by byte count.

## Test plan
- `BYTES=4`, frame "123456789" followed by FCS bytes 0x26, 0x39, 0xF4, 0xCB (13 bytes in beats of 4/4/4/1, `in_last_bytes=1`) -> one cycle after EOF: `out_valid=1`, `out_error=0`, `out_runt=1`, `out_len=13`.
- Same frame with bit 0 of byte 2 flipped -> `out_error=1`; `stat_bad` +1 and `stat_ok` unchanged.
- 64-byte frame (60 bytes of 0x00 plus model-computed FCS), with `in_valid` low for 3 cycles mid-frame -> `out_error=0`, `out_runt=0`, `out_len=64`; `stat_ok` +1.
- SOF reissued in the 3rd beat of a frame, then a good 64-byte frame completes -> exactly one verdict with `out_error=0`; `stat_abort=1`.
- Two good frames back to back, the second's SOF in the cycle after the first's EOF, plus a single-beat SOF+EOF frame -> three `out_valid` pulses, each 1 cycle after its EOF; the single-beat frame flagged `out_runt=1`.
- `reset` asserted for 1 cycle mid-frame, then EOF driven -> no `out_valid`; all outputs and counters 0.

Source files
------------

// File: rtl/fcs_pkg.sv
// fcs_pkg: CRC-32 constants, reflected byte update and checker FSM states.
package fcs_pkg;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  typedef enum logic {S_IDLE, S_FRAME} state_t;
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    return c;
  endfunction
endpackage

// File: rtl/fcs_check_parallel_crc32_parallel_update.sv
// crc32_parallel_update: chained byte-wise CRC-32, one intermediate result per byte count.
module crc32_parallel_update
  import fcs_pkg::*;
#(
  parameter int BYTES = 4
) (
  input  logic [31:0]        i_crc,
  input  logic [8*BYTES-1:0] i_data,
  output logic [31:0]        o_crc [BYTES]
);
  logic [31:0] w_c;
  always_comb begin
    w_c = i_crc;
    for (int i = 0; i < BYTES; i++) begin
      w_c = crc32_byte(w_c, i_data[8*i +: 8]);
      o_crc[i] = w_c;
    end
  end
endmodule

// File: rtl/fcs_check_parallel.sv
// fcs_check_parallel: multi-byte-per-beat Ethernet FCS checker with runt detection.
// Optional statistics counters are built when FCS_CHECK_STATS_EN is defined.
module fcs_check_parallel
  import fcs_pkg::*;
#(
  parameter int BYTES   = 4,
  parameter int MIN_LEN = 64,
  parameter int CNT_W   = 32,
  localparam int DATA_W = 8 * BYTES,
  localparam int LB_W   = $clog2(BYTES) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic              in_eof,
  input  logic [DATA_W-1:0] in_data,
  input  logic [LB_W-1:0]   in_last_bytes,
  output logic              out_valid,
  output logic              out_error,
  output logic              out_runt,
  output logic [15:0]       out_len
`ifdef FCS_CHECK_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_ok,
  output logic [CNT_W-1:0]  stat_bad,
  output logic [CNT_W-1:0]  stat_abort
`endif
);
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
  state_t r_state, w_state_next;
  logic [31:0] r_crc;
  logic [15:0] r_len;
  logic [LB_W-1:0] w_cnt;
  logic [IW-1:0] w_idx;
  logic [31:0] w_crcs [BYTES];
  logic [31:0] w_crc_next;
  logic [16:0] w_len_sum;
  logic [15:0] w_len_next;
  logic w_accept, w_verdict, w_bad_crc, w_runt;
  assign w_cnt = (!in_eof || in_last_bytes == '0 || in_last_bytes > LB_W'(BYTES)) ? LB_W'(BYTES) : in_last_bytes;
  assign w_idx = IW'(w_cnt - 1'b1);
  crc32_parallel_update #(.BYTES(BYTES)) u_upd (
    .i_crc  (in_sof ? CRC32_INIT : r_crc),
    .i_data (in_data),
    .o_crc  (w_crcs)
  );
  assign w_crc_next = w_crcs[w_idx];
  assign w_len_sum  = {1'b0, in_sof ? 16'h0 : r_len} + 17'(w_cnt);
  assign w_len_next = w_len_sum[16] ? 16'hFFFF : w_len_sum[15:0];
  assign w_accept   = in_valid && (in_sof || r_state == S_FRAME);
  assign w_verdict  = w_accept && in_eof;
  assign w_bad_crc  = w_crc_next != CRC32_RESIDUE;
  assign w_runt     = w_len_next < 16'(MIN_LEN);
  always_comb begin
    w_state_next = r_state;
    if (w_accept) w_state_next = in_eof ? S_IDLE : S_FRAME;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_crc     <= CRC32_INIT;
      r_len     <= '0;
      out_valid <= 1'b0;
      out_error <= 1'b0;
      out_runt  <= 1'b0;
      out_len   <= '0;
    end else begin
      r_state   <= w_state_next;
      out_valid <= w_verdict;
      if (w_accept) begin
        r_crc <= w_crc_next;
        r_len <= w_len_next;
      end
      if (w_verdict) begin
        out_error <= w_bad_crc;
        out_runt  <= w_runt;
        out_len   <= w_len_next;
      end
    end
  end
`ifdef FCS_CHECK_STATS_EN
  logic [CNT_W-1:0] r_ok, r_bad, r_abort;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ok    <= '0;
      r_bad   <= '0;
      r_abort <= '0;
    end else begin
      if (w_verdict && !(w_bad_crc || w_runt) && r_ok != '1) r_ok <= r_ok + 1'b1;
      if (w_verdict && (w_bad_crc || w_runt) && r_bad != '1) r_bad <= r_bad + 1'b1;
      if (in_valid && in_sof && r_state == S_FRAME && r_abort != '1) r_abort <= r_abort + 1'b1;
    end
  end
  assign stat_ok    = r_ok;
  assign stat_bad   = r_bad;
  assign stat_abort = r_abort;
`endif
endmodule

// File: tb/tb_fcs_check_parallel.sv
// tb_fcs_check_parallel: directed checks of verdict, length, runt, gaps, aborts and reset.
module tb_fcs_check_parallel;
  logic clk = 0, reset = 1;
  logic in_valid = 0, in_sof = 0, in_eof = 0;
  logic [31:0] in_data = '0;
  logic [2:0] in_last_bytes = '0;
  logic out_valid, out_error, out_runt;
  logic [15:0] out_len;
  int checks = 0, failures = 0, pulses = 0, p0;
  logic [7:0] fb [0:127];
  logic [31:0] fcs;
`ifdef FCS_CHECK_STATS_EN
  logic [31:0] stat_ok, stat_bad, stat_abort;
  int exp_ok = 0, exp_bad = 0, exp_abort = 0;
`endif

  fcs_check_parallel #(.BYTES(4), .MIN_LEN(64), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
    .in_data(in_data), .in_last_bytes(in_last_bytes), .out_valid(out_valid),
    .out_error(out_error), .out_runt(out_runt), .out_len(out_len)
`ifdef FCS_CHECK_STATS_EN
    , .stat_ok(stat_ok), .stat_bad(stat_bad), .stat_abort(stat_abort)
`endif
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (out_valid) pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic stats_chk(input string tag);
`ifdef FCS_CHECK_STATS_EN
    chk({tag, "_ok"}, stat_ok, exp_ok);
    chk({tag, "_bad"}, stat_bad, exp_bad);
    chk({tag, "_abort"}, stat_abort, exp_abort);
`endif
  endtask

  task automatic beat(input logic sof, input logic eof, input logic [31:0] d, input logic [2:0] lb);
    in_valid = 1; in_sof = sof; in_eof = eof; in_data = d; in_last_bytes = lb;
    @(posedge clk); #1;
    in_valid = 0; in_sof = 0; in_eof = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input int gap_after, input int gap);
    int nb, rem;
    logic [31:0] d;
    nb = (n + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 4; k++) d[8*k +: 8] = (4*b + k < n) ? fb[4*b + k] : 8'h00;
      rem = n - 4*b;
      beat(b == 0, b == nb - 1, d, (rem >= 4) ? 3'd4 : 3'(rem));
      if (b < nb - 1) chk("no_early_valid", {31'b0, out_valid}, 0);
      if (b == gap_after) idle(gap);
    end
  endtask

  // Bit-at-a-time reference CRC; the FCS transmitted is its complement, LSB byte first.
  task automatic make_zero64();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 60; i++) begin
      fb[i] = 8'h00;
      for (int j = 0; j < 8; j++) c = (c[0] ^ fb[i][j]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    fcs = ~c;
    for (int k = 0; k < 4; k++) fb[60 + k] = fcs[8*k +: 8];
  endtask

  task automatic load_123();
    for (int i = 0; i < 9; i++) fb[i] = 8'h31 + 8'(i);
    fb[9] = 8'h26; fb[10] = 8'h39; fb[11] = 8'hF4; fb[12] = 8'hCB;
  endtask

  initial begin
    idle(3);
    reset = 0;
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_error", {31'b0, out_error}, 0);
    chk("rst_runt", {31'b0, out_runt}, 0);
    chk("rst_len", {16'b0, out_len}, 0);
    stats_chk("rst");
    beat(0, 1, 32'h12345678, 3'd4);
    chk("idle_drop_valid", {31'b0, out_valid}, 0);
    load_123();
    send(13, -1, 0);
    chk("t1_valid", {31'b0, out_valid}, 1);
    chk("t1_error", {31'b0, out_error}, 0);
    chk("t1_runt", {31'b0, out_runt}, 1);
    chk("t1_len", {16'b0, out_len}, 13);
`ifdef FCS_CHECK_STATS_EN
    exp_bad++;
`endif
    idle(1);
    chk("t1_pulse_one", {31'b0, out_valid}, 0);
    chk("t1_len_hold", {16'b0, out_len}, 13);
    stats_chk("t1");
    fb[2] = 8'h32;
    send(13, -1, 0);
    chk("t2_valid", {31'b0, out_valid}, 1);
    chk("t2_error", {31'b0, out_error}, 1);
    chk("t2_runt", {31'b0, out_runt}, 1);
`ifdef FCS_CHECK_STATS_EN
    exp_bad++;
`endif
    idle(1);
    stats_chk("t2");
    make_zero64();
    send(64, 5, 3);
    chk("t3_valid", {31'b0, out_valid}, 1);
    chk("t3_error", {31'b0, out_error}, 0);
    chk("t3_runt", {31'b0, out_runt}, 0);
    chk("t3_len", {16'b0, out_len}, 64);
`ifdef FCS_CHECK_STATS_EN
    exp_ok++;
`endif
    idle(1);
    stats_chk("t3");
    p0 = pulses;
    beat(1, 0, 32'hDEADBEEF, 3'd4);
    beat(0, 0, 32'h01020304, 3'd4);
    send(64, -1, 0);
    chk("t4_valid", {31'b0, out_valid}, 1);
    chk("t4_error", {31'b0, out_error}, 0);
    chk("t4_len", {16'b0, out_len}, 64);
    idle(1);
    chk("t4_pulses", pulses - p0, 1);
`ifdef FCS_CHECK_STATS_EN
    exp_ok++; exp_abort++;
`endif
    stats_chk("t4");
    p0 = pulses;
    send(64, -1, 0);
    chk("t5a_valid", {31'b0, out_valid}, 1);
    send(64, -1, 0);
    chk("t5b_valid", {31'b0, out_valid}, 1);
    chk("t5b_error", {31'b0, out_error}, 0);
    beat(1, 1, 32'hA5A5A5A5, 3'd0);
    chk("t5c_valid", {31'b0, out_valid}, 1);
    chk("t5c_runt", {31'b0, out_runt}, 1);
    chk("t5c_len", {16'b0, out_len}, 4);
    idle(1);
    chk("t5_pulses", pulses - p0, 3);
`ifdef FCS_CHECK_STATS_EN
    exp_ok += 2; exp_bad++;
`endif
    stats_chk("t5");
    p0 = pulses;
    beat(1, 0, 32'h11111111, 3'd4);
    beat(0, 0, 32'h22222222, 3'd4);
    reset = 1;
    idle(1);
    reset = 0;
    beat(0, 1, 32'h33333333, 3'd4);
    chk("t6_valid", {31'b0, out_valid}, 0);
    idle(1);
    chk("t6_pulses", pulses - p0, 0);
    chk("t6_error", {31'b0, out_error}, 0);
    chk("t6_runt", {31'b0, out_runt}, 0);
    chk("t6_len", {16'b0, out_len}, 0);
`ifdef FCS_CHECK_STATS_EN
    exp_ok = 0; exp_bad = 0; exp_abort = 0;
`endif
    stats_chk("t6");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
